// File: rtl/spi_sd_block_reader.sv
// ============================================================================
// Module   : spi_sd_block_reader
// Brief    : SD-card CMD17 single-block read sequencer over a byte SPI engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sd_block_reader #(
    parameter int RESP_TIMEOUT  = 8,
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int BLOCK_BYTES   = 512
) (
    input  logic                           spi_clk_i,
    input  logic                           spi_rst_i,
    input  logic                           spi_initdone_i,
    input  logic                           rd_start_i,
    input  logic [31:0]                    rd_addr_i,
    output logic                           rd_busy_o,
    output logic                           rd_done_o,
    output logic                           rd_err_o,
    output logic [2:0]                     rd_errcode_o,
    output logic [15:0]                    crc_o,
    output logic                           spi_ss_o,
    output logic                           xfer_req_o,
    output logic [7:0]                     xfer_tx_o,
    input  logic                           xfer_done_i,
    input  logic [7:0]                     xfer_rx_i,
    output logic                           buf_we_o,
    output logic [$clog2(BLOCK_BYTES)-1:0] buf_addr_o,
    output logic [7:0]                     buf_data_o
);

    localparam int AW   = $clog2(BLOCK_BYTES);
    localparam int CW   = (AW > 3) ? AW : 3;
    localparam int PMAX = (RESP_TIMEOUT > TOKEN_TIMEOUT) ? RESP_TIMEOUT : TOKEN_TIMEOUT;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [PW-1:0] C_RESP_TO  = PW'(RESP_TIMEOUT);
    localparam logic [PW-1:0] C_TOK_TO   = PW'(TOKEN_TIMEOUT);
    localparam logic [CW-1:0] C_LAST     = CW'(BLOCK_BYTES - 1);
    localparam logic [CW-1:0] C_CMD_LAST = CW'(5);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_R1WAIT  = 3'd2,
        S_TOKWAIT = 3'd3,
        S_DATA    = 3'd4,
        S_CRC     = 3'd5,
        S_TRAIL   = 3'd6,
        S_FIN     = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic            pend_q, pend_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [2:0]      errcode_q, errcode_d;
    logic [2:0]      lat_code_q, lat_code_d;
    logic [15:0]     crc_q, crc_d;
    logic            ss_q, ss_d;
    logic            req_q, req_d;
    logic [7:0]      tx_q, tx_d;
    logic            we_q, we_d;
    logic [AW-1:0]   baddr_q, baddr_d;
    logic [7:0]      bdata_q, bdata_d;

    logic            w_rx_done;
    logic [PW-1:0]   w_poll_inc;
    logic [7:0]      w_cmd_next;
    logic            w_to_trail;
    logic [2:0]      w_code;

    // Only a completion that answers our own outstanding request is consumed.
    assign w_rx_done  = xfer_done_i && pend_q;
    assign w_poll_inc = (poll_q == {PW{1'b1}}) ? poll_q : poll_q + PW'(1);

    always_comb begin
        w_cmd_next = 8'h01;
        case (cnt_q)
            CW'(0):  w_cmd_next = addr_q[31:24];
            CW'(1):  w_cmd_next = addr_q[23:16];
            CW'(2):  w_cmd_next = addr_q[15:8];
            CW'(3):  w_cmd_next = addr_q[7:0];
            default: w_cmd_next = 8'h01;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        poll_d     = poll_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        errcode_d  = errcode_q;
        lat_code_d = lat_code_q;
        crc_d      = crc_q;
        ss_d       = ss_q;
        req_d      = 1'b0;
        tx_d       = tx_q;
        we_d       = 1'b0;
        baddr_d    = baddr_q;
        bdata_d    = bdata_q;
        w_to_trail = 1'b0;
        w_code     = 3'd0;

        case (state_q)
            S_IDLE: begin
                if (rd_start_i) begin
                    if (spi_initdone_i) begin
                        state_d    = S_CMD;
                        addr_d     = rd_addr_i;
                        cnt_d      = '0;
                        poll_d     = '0;
                        lat_code_d = 3'd0;
                        errcode_d  = 3'd0;
                        busy_d     = 1'b1;
                        ss_d       = 1'b0;
                        req_d      = 1'b1;
                        tx_d       = 8'h51;
                    end else begin
                        err_d     = 1'b1;
                        errcode_d = 3'd5;
                    end
                end
            end
            S_CMD: begin
                if (w_rx_done) begin
                    req_d = 1'b1;
                    if (cnt_q == C_CMD_LAST) begin
                        state_d = S_R1WAIT;
                        poll_d  = '0;
                        tx_d    = 8'hFF;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        tx_d  = w_cmd_next;
                    end
                end
            end
            S_R1WAIT: begin
                if (w_rx_done) begin
                    if (xfer_rx_i == 8'hFF) begin
                        poll_d = w_poll_inc;
                        if (w_poll_inc >= C_RESP_TO) begin
                            w_to_trail = 1'b1;
                            w_code     = 3'd2;
                        end else begin
                            req_d = 1'b1;
                            tx_d  = 8'hFF;
                        end
                    end else if (xfer_rx_i == 8'h00) begin
                        state_d = S_TOKWAIT;
                        poll_d  = '0;
                        req_d   = 1'b1;
                        tx_d    = 8'hFF;
                    end else begin
                        w_to_trail = 1'b1;
                        w_code     = 3'd1;
                    end
                end
            end
            S_TOKWAIT: begin
                if (w_rx_done) begin
                    if (xfer_rx_i == 8'hFE) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        tx_d    = 8'hFF;
                    end else if (xfer_rx_i[7:4] == 4'h0) begin
                        w_to_trail = 1'b1;
                        w_code     = 3'd3;
                    end else begin
                        poll_d = w_poll_inc;
                        if (w_poll_inc >= C_TOK_TO) begin
                            w_to_trail = 1'b1;
                            w_code     = 3'd4;
                        end else begin
                            req_d = 1'b1;
                            tx_d  = 8'hFF;
                        end
                    end
                end
            end
            S_DATA: begin
                if (w_rx_done) begin
                    we_d    = 1'b1;
                    baddr_d = cnt_q[AW-1:0];
                    bdata_d = xfer_rx_i;
                    req_d   = 1'b1;
                    tx_d    = 8'hFF;
                    if (cnt_q == C_LAST) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_CRC: begin
                if (w_rx_done) begin
                    if (cnt_q == '0) begin
                        crc_d[15:8] = xfer_rx_i;
                        cnt_d       = CW'(1);
                        req_d       = 1'b1;
                        tx_d        = 8'hFF;
                    end else begin
                        crc_d[7:0] = xfer_rx_i;
                        w_to_trail = 1'b1;
                    end
                end
            end
            S_TRAIL: begin
                if (w_rx_done) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    if (lat_code_q != 3'd0) begin
                        err_d     = 1'b1;
                        errcode_d = lat_code_q;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Deselect the card before the trailer byte so it releases MISO.
        if (w_to_trail) begin
            state_d    = S_TRAIL;
            ss_d       = 1'b1;
            req_d      = 1'b1;
            tx_d       = 8'hFF;
            lat_code_d = w_code;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (w_rx_done) begin
            pend_d = 1'b0;
        end
        if (req_d) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge spi_clk_i) begin
        if (spi_rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'h0;
            cnt_q      <= '0;
            poll_q     <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            errcode_q  <= 3'd0;
            lat_code_q <= 3'd0;
            crc_q      <= 16'h0;
            ss_q       <= 1'b1;
            req_q      <= 1'b0;
            tx_q       <= 8'hFF;
            we_q       <= 1'b0;
            baddr_q    <= '0;
            bdata_q    <= 8'h0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            poll_q     <= poll_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            errcode_q  <= errcode_d;
            lat_code_q <= lat_code_d;
            crc_q      <= crc_d;
            ss_q       <= ss_d;
            req_q      <= req_d;
            tx_q       <= tx_d;
            we_q       <= we_d;
            baddr_q    <= baddr_d;
            bdata_q    <= bdata_d;
        end
    end

    assign rd_busy_o    = busy_q;
    assign rd_done_o    = done_q;
    assign rd_err_o     = err_q;
    assign rd_errcode_o = errcode_q;
    assign crc_o        = crc_q;
    assign spi_ss_o     = ss_q;
    assign xfer_req_o   = req_q;
    assign xfer_tx_o    = tx_q;
    assign buf_we_o     = we_q;
    assign buf_addr_o   = baddr_q;
    assign buf_data_o   = bdata_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_sd_block_reader.sv
// ============================================================================
// Module   : tb_spi_sd_block_reader
// Brief    : Self-checking bench: SPI byte-engine model plus CMD17 reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_sd_block_reader;

    localparam int RESP_TO = 8;
    localparam int TOK_TO  = 16;
    localparam int BLK     = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        initdone;
    logic        rd_start;
    logic [31:0] rd_addr;
    logic        rd_busy_o, rd_done_o, rd_err_o;
    logic [2:0]  rd_errcode_o;
    logic [15:0] crc_o;
    logic        spi_ss_o, xfer_req_o;
    logic [7:0]  xfer_tx_o;
    logic        xfer_done_i;
    logic [7:0]  xfer_rx_i;
    logic        buf_we_o;
    logic [8:0]  buf_addr_o;
    logic [7:0]  buf_data_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx_script[$];
    logic [7:0] tx_log[$];
    logic       ss_log[$];
    logic [8:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    logic [2:0] last_code = 3'd0;
    int         proto_err = 0;
    bit         eng_busy  = 1'b0;
    int         eng_lat   = 0;
    int         eng_idx   = 0;
    bit         done_prev = 1'b0;

    always #5 clk = ~clk;

    spi_sd_block_reader #(
        .RESP_TIMEOUT  (RESP_TO),
        .TOKEN_TIMEOUT (TOK_TO),
        .BLOCK_BYTES   (BLK)
    ) dut (
        .spi_clk_i      (clk),
        .spi_rst_i      (rst),
        .spi_initdone_i (initdone),
        .rd_start_i     (rd_start),
        .rd_addr_i      (rd_addr),
        .rd_busy_o      (rd_busy_o),
        .rd_done_o      (rd_done_o),
        .rd_err_o       (rd_err_o),
        .rd_errcode_o   (rd_errcode_o),
        .crc_o          (crc_o),
        .spi_ss_o       (spi_ss_o),
        .xfer_req_o     (xfer_req_o),
        .xfer_tx_o      (xfer_tx_o),
        .xfer_done_i    (xfer_done_i),
        .xfer_rx_i      (xfer_rx_i),
        .buf_we_o       (buf_we_o),
        .buf_addr_o     (buf_addr_o),
        .buf_data_o     (buf_data_o)
    );

    function automatic logic [7:0] rx_at(input int i);
        return (i < rx_script.size()) ? rx_script[i] : 8'hFF;
    endfunction

    // Card behaviour from the protocol rules: outcome, transfer count, data window.
    function automatic void ref_model(output int n, output logic [2:0] code,
                                      output int nwr, output int dstart,
                                      output logic [15:0] crc);
        int pos;
        bit hit;
        logic [7:0] b;
        pos = 6; code = 3'd0; nwr = 0; dstart = 0; crc = 16'h0; hit = 1'b0; b = 8'hFF;
        for (int k = 0; k < RESP_TO && !hit; k++) begin
            b = rx_at(pos); pos++; hit = (b != 8'hFF);
        end
        if (!hit) code = 3'd2;
        else if (b != 8'h00) code = 3'd1;
        else begin
            hit = 1'b0;
            for (int k = 0; k < TOK_TO && !hit; k++) begin
                b = rx_at(pos); pos++; hit = (b == 8'hFE) || (b[7:4] == 4'h0);
            end
            if (!hit) code = 3'd4;
            else if (b != 8'hFE) code = 3'd3;
            else begin
                dstart = pos; nwr = BLK; pos += BLK;
                crc = {rx_at(pos), rx_at(pos + 1)}; pos += 2;
            end
        end
        n = pos + 1;
    endfunction

    // Byte engine: random latency, one transfer at a time, answers from rx_script.
    initial begin
        xfer_done_i = 1'b0;
        xfer_rx_i   = 8'h00;
        forever begin
            @(negedge clk);
            xfer_done_i = 1'b0;
            if (rst) begin
                eng_busy  = 1'b0;
                done_prev = 1'b0;
            end else begin
                if (done_prev && !(xfer_req_o || rd_done_o || rd_err_o)) proto_err++;
                done_prev = 1'b0;
                if (xfer_req_o) begin
                    if (eng_busy || !rd_busy_o) proto_err++;
                    tx_log.push_back(xfer_tx_o);
                    ss_log.push_back(spi_ss_o);
                    eng_busy = 1'b1;
                    eng_lat  = $urandom_range(0, 3);
                end else if (eng_busy) begin
                    if (eng_lat == 0) begin
                        xfer_done_i = 1'b1;
                        xfer_rx_i   = rx_at(eng_idx);
                        eng_idx++;
                        eng_busy  = 1'b0;
                        done_prev = 1'b1;
                    end else begin
                        eng_lat--;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (buf_we_o) begin
                wr_addr_q.push_back(buf_addr_o);
                wr_data_q.push_back(buf_data_o);
            end
            if (rd_done_o) done_cnt++;
            if (rd_err_o) begin
                err_cnt++;
                last_code = rd_errcode_o;
            end
            if ((rd_done_o || rd_err_o) && rd_busy_o) proto_err++;
        end
    end

    task automatic clear_logs();
        tx_log.delete(); ss_log.delete();
        wr_addr_q.delete(); wr_data_q.delete();
        eng_idx = 0; proto_err = 0;
    endtask

    task automatic run_read(input logic [31:0] addr, input int restart_at, input string tag);
        int n, nwr, dstart, base, d0, e0, bad;
        logic [2:0] code;
        logic [15:0] crc;
        logic [7:0] exp_b;
        ref_model(n, code, nwr, dstart, crc);
        clear_logs();
        d0 = done_cnt; e0 = err_cnt; base = d0 + e0;
        @(negedge clk);
        rd_addr = addr; rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0; rd_addr = $urandom();
        vectors++;
        if ({rd_busy_o, spi_ss_o, xfer_req_o, xfer_tx_o} !== {1'b1, 1'b0, 1'b1, 8'h51}) begin
            miscompares++;
            $display("FAIL %s start: busy/ss/req/tx=%b%b%b/%h expected 101/51", tag,
                     rd_busy_o, spi_ss_o, xfer_req_o, xfer_tx_o);
        end
        for (int c = 0; c < 8000; c++) begin
            if ((done_cnt + err_cnt) != base) break;
            @(negedge clk);
            rd_start = (c == restart_at);
        end
        rd_start = 1'b0;
        vectors++;
        if ((done_cnt + err_cnt) == base) begin
            miscompares++;
            $display("FAIL %s timeout: no done/err pulse within cycle budget", tag);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if ({done_cnt - d0, err_cnt - e0} !== {(code == 0) ? 1 : 0, (code == 0) ? 0 : 1}) begin
            miscompares++;
            $display("FAIL %s outcome: done=%0d err=%0d expected code %0d", tag,
                     done_cnt - d0, err_cnt - e0, code);
        end
        vectors++;
        if (rd_errcode_o !== code || (code != 0 && last_code !== code)) begin
            miscompares++;
            $display("FAIL %s errcode: got %0d expected %0d", tag, rd_errcode_o, code);
        end
        vectors++;
        if (tx_log.size() != n) begin
            miscompares++;
            $display("FAIL %s xfer_count: got %0d expected %0d", tag, tx_log.size(), n);
        end
        bad = 0;
        for (int i = 0; i < tx_log.size(); i++) begin
            case (i)
                0: exp_b = 8'h51;
                1: exp_b = addr[31:24];
                2: exp_b = addr[23:16];
                3: exp_b = addr[15:8];
                4: exp_b = addr[7:0];
                5: exp_b = 8'h01;
                default: exp_b = 8'hFF;
            endcase
            if (tx_log[i] !== exp_b || ss_log[i] !== (i == n - 1)) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s tx_bytes/cs: %0d bad transfers, expected 0", tag, bad);
        end
        vectors++;
        if (wr_addr_q.size() != nwr) begin
            miscompares++;
            $display("FAIL %s buf_writes: got %0d expected %0d", tag, wr_addr_q.size(), nwr);
        end
        bad = 0;
        for (int k = 0; k < wr_addr_q.size(); k++)
            if (wr_addr_q[k] !== 9'(k) || wr_data_q[k] !== rx_at(dstart + k)) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s buf_content: %0d bad writes, expected 0", tag, bad);
        end
        if (code == 0) begin
            vectors++;
            if (crc_o !== crc) begin
                miscompares++;
                $display("FAIL %s crc: got %h expected %h", tag, crc_o, crc);
            end
        end
        vectors++;
        if (proto_err != 0 || spi_ss_o !== 1'b1 || rd_busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s handshake: proto_err=%0d ss=%b busy=%b expected 0/1/0", tag,
                     proto_err, spi_ss_o, rd_busy_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; initdone = 1'b1; rd_start = 1'b0; rd_addr = 32'h0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({spi_ss_o, xfer_tx_o, xfer_req_o, rd_busy_o, rd_done_o, rd_err_o, rd_errcode_o,
             crc_o, buf_we_o, buf_addr_o, buf_data_o} !==
            {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 9'd0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_values: got ss=%b tx=%h req=%b busy=%b done=%b err=%b code=%0d crc=%h we=%b a=%h d=%h",
                     spi_ss_o, xfer_tx_o, xfer_req_o, rd_busy_o, rd_done_o, rd_err_o,
                     rd_errcode_o, crc_o, buf_we_o, buf_addr_o, buf_data_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        rx_script.delete();
        repeat (6) rx_script.push_back(8'hFF);
        rx_script.push_back(8'hFF); rx_script.push_back(8'h00);
        repeat (3) rx_script.push_back(8'hFF);
        rx_script.push_back(8'hFE);
        for (int i = 0; i < BLK; i++) rx_script.push_back(8'(i));
        rx_script.push_back(8'hAB); rx_script.push_back(8'hCD);
        run_read(32'h0000_1234, -1, "nominal");
    endtask

    task automatic test_errors();
        rx_script.delete();
        repeat (7) rx_script.push_back(8'hFF);
        rx_script.push_back(8'h05);
        run_read($urandom(), -1, "r1_error");
        rx_script.delete();
        run_read($urandom(), -1, "r1_timeout");
        rx_script.delete();
        repeat (6) rx_script.push_back(8'hFF);
        rx_script.push_back(8'h00);
        run_read($urandom(), -1, "token_timeout");
        rx_script.delete();
        repeat (6) rx_script.push_back(8'hFF);
        rx_script.push_back(8'h00); rx_script.push_back(8'hFF); rx_script.push_back(8'h08);
        run_read($urandom(), -1, "data_err_token");
    endtask

    task automatic test_not_ready();
        int e0;
        clear_logs();
        e0 = err_cnt;
        initdone = 1'b0;
        @(negedge clk);
        rd_start = 1'b1; rd_addr = $urandom();
        @(negedge clk);
        rd_start = 1'b0;
        vectors++;
        if ({rd_err_o, rd_errcode_o, rd_busy_o, spi_ss_o, xfer_req_o} !== {1'b1, 3'd5, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL not_ready: err=%b code=%0d busy=%b ss=%b req=%b expected 1/5/0/1/0",
                     rd_err_o, rd_errcode_o, rd_busy_o, spi_ss_o, xfer_req_o);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (tx_log.size() != 0 || (err_cnt - e0) != 1) begin
            miscompares++;
            $display("FAIL not_ready_quiet: xfers=%0d errs=%0d expected 0/1", tx_log.size(), err_cnt - e0);
        end
        initdone = 1'b1;
    endtask

    task automatic build_random(input int kind);
        int p, t;
        rx_script.delete();
        repeat (6) rx_script.push_back(8'($urandom()));
        p = (kind == 2) ? RESP_TO + 2 : $urandom_range(0, RESP_TO - 1);
        repeat (p) rx_script.push_back(8'hFF);
        rx_script.push_back((kind == 0) ? 8'($urandom_range(1, 8'hFE)) : 8'h00);
        t = $urandom_range(0, TOK_TO - 1);
        repeat (t) rx_script.push_back(8'($urandom_range(8'h10, 8'hFD)));
        rx_script.push_back((kind == 1) ? 8'($urandom_range(0, 15)) : 8'hFE);
        repeat (BLK + 2) rx_script.push_back(8'($urandom()));
    endtask

    task automatic test_start_while_busy();
        build_random(3);
        run_read($urandom(), 40, "start_while_busy");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 5; r++) begin
            build_random((r == 1) ? 0 : (r == 3) ? 1 : $urandom_range(2, 9));
            run_read($urandom(), -1, "random");
        end
    endtask

    task automatic test_reset_mid_data();
        build_random(3);
        clear_logs();
        @(negedge clk);
        rd_addr = $urandom(); rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        for (int c = 0; c < 4000 && wr_addr_q.size() < 100; c++) @(negedge clk);
        vectors++;
        if (wr_addr_q.size() < 100) begin
            miscompares++;
            $display("FAIL mid_reset_reach: got %0d writes expected 100", wr_addr_q.size());
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({spi_ss_o, xfer_tx_o, xfer_req_o, rd_busy_o, rd_done_o, rd_err_o, rd_errcode_o,
             crc_o, buf_we_o, buf_addr_o, buf_data_o} !==
            {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 9'd0, 8'h00}) begin
            miscompares++;
            $display("FAIL mid_reset_values: got ss=%b tx=%h req=%b busy=%b done=%b err=%b code=%0d crc=%h we=%b a=%h d=%h",
                     spi_ss_o, xfer_tx_o, xfer_req_o, rd_busy_o, rd_done_o, rd_err_o,
                     rd_errcode_o, crc_o, buf_we_o, buf_addr_o, buf_data_o);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (xfer_req_o !== 1'b0 || rd_busy_o !== 1'b0 || spi_ss_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_idle: req=%b busy=%b ss=%b expected 0/0/1", xfer_req_o, rd_busy_o, spi_ss_o);
        end
        build_random(3);
        run_read($urandom(), -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_errors();
        test_not_ready();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_sd_block_reader.md
# spi_sd_block_reader

Sequencer that performs one SD-card single-block read (CMD17) over the shared byte-level SPI transfer engine once card initialisation has completed. It builds the command frame, polls for the R1 response and the data start token, streams the 512 data bytes into the boot buffer, captures the CRC, and releases chip select. It sits between the boot controller (start/done/error) and the SPI byte engine.

## Interface
- RESP_TIMEOUT, 8: maximum 0xFF polls while waiting for R1.
- TOKEN_TIMEOUT, 4096: maximum polls while waiting for the data token.
- BLOCK_BYTES, 512: data bytes per block; buf_addr_o width is clog2(BLOCK_BYTES).
- spi_clk_i  in  1  system clock; every flop is clocked on the rising edge.
- spi_rst_i  in  1  synchronous, active-high reset.
- spi_initdone_i  in  1  card init complete; reads are allowed only while high.
- rd_start_i  in  1  one-cycle start request; sampled only in IDLE.
- rd_addr_i  in  32  block address (SDHC block units); captured on an accepted start.
- rd_busy_o  out  1  high from the accepted start until the cycle rd_done_o or rd_err_o fires.
- rd_done_o  out  1  one-cycle pulse on successful completion.
- rd_err_o  out  1  one-cycle pulse on failure.
- rd_errcode_o  out  3  valid with rd_err_o; held until the next start.
- crc_o  out  16  received block CRC (MSB byte first); not checked.
- spi_ss_o  out  1  card chip select, active low.
- xfer_req_o  out  1  one-cycle pulse that launches a byte transfer.
- xfer_tx_o  out  8  byte to send; stable from the req pulse until xfer_done_i.
- xfer_done_i  in  1  one-cycle pulse from the engine when a byte completes.
- xfer_rx_i  in  8  received byte; valid with xfer_done_i.
- buf_we_o  out  1  buffer write strobe.
- buf_addr_o  out  9  buffer byte index.
- buf_data_o  out  8  buffer write data.

## Operation
- States: IDLE, CMD, R1WAIT, TOKWAIT, DATA, CRC, TRAIL, FIN.
- IDLE
  - rd_start_i with spi_initdone_i=1: capture the address, clear the counters, go to CMD.
  - rd_start_i with spi_initdone_i=0: error code 5; no transfer is launched.
- CMD: send 6 bytes in order: 0x51, addr[31:24], addr[23:16], addr[15:8], addr[7:0], 0x01.
- R1WAIT
  - Send 0xFF each byte.
  - rx=0xFF: increment the poll counter. When the count reaches RESP_TIMEOUT, error code 2.
  - rx≠0xFF: the byte is R1. R1=0x00 goes to TOKWAIT; any other value is error code 1.
- TOKWAIT
  - Send 0xFF each byte.
  - rx=0xFE goes to DATA.
  - rx[7:4]=0000 is a data error token: error code 3.
  - Any other value counts as a poll. When the count reaches TOKEN_TIMEOUT, error code 4.
- DATA
  - Send 0xFF for BLOCK_BYTES bytes.
  - Each rx is written to the buffer at an index running from 0 to BLOCK_BYTES-1.
  - After the last byte, go to CRC.
- CRC: send 0xFF twice; the first rx goes to crc_o[15:8], the second to crc_o[7:0]; go to TRAIL.
- TRAIL: spi_ss_o=1; send one 0xFF byte (8 clocks with CS high); go to FIN.
- FIN: pulse rd_done_o, or rd_err_o if an error was latched; return to IDLE.
- Any error (codes 1-4): latch the code, go directly to TRAIL, then FIN.
- rd_start_i while busy is ignored. xfer_done_i in IDLE is ignored.
- Byte engine handshake:
  - At most one transfer outstanding.
  - The next xfer_req_o is issued no earlier than the cycle after xfer_done_i.
  - xfer_req_o is never asserted in IDLE or FIN.

## Timing
- Reset values (every output):
  - spi_ss_o=1, xfer_tx_o=0xFF.
  - xfer_req_o=0, rd_busy_o=0, rd_done_o=0, rd_err_o=0.
  - rd_errcode_o=0, crc_o=0.
  - buf_we_o=0, buf_addr_o=0, buf_data_o=0.
- Reset has priority over every state. A reset mid-read returns to IDLE on the next edge with CS high. A pending xfer_done_i is discarded.
- Start accepted at edge N:
  - From N+1: rd_busy_o=1, spi_ss_o=0.
  - At N+1: xfer_req_o=1 with xfer_tx_o=0x51.
- After xfer_done_i at cycle M, the next xfer_req_o is at M+1.
- DATA byte sampled at cycle M: buf_we_o=1 at M+1 with registered buf_addr_o and buf_data_o.
- spi_ss_o goes high in the cycle TRAIL is entered, before the trailer req.
- FIN:
  - rd_done_o/rd_err_o are asserted for one cycle, in the cycle after the trailer's xfer_done_i.
  - rd_busy_o drops in that same cycle.
- Error 5: rd_err_o at N+1; rd_busy_o stays 0; spi_ss_o stays 1.
- Counters saturate at the terminal count and do not wrap.

## Test plan
- Nominal read, addr 0x00001234; engine model answers R1=0x00 on the 2nd poll, then 3×0xFF, then 0xFE, data i&0xFF, CRC 0xAB 0xCD -> tx sequence is 51 00 00 12 34 01; 512 buffer writes, index 0-511, data = index; crc_o=0xABCD; rd_done_o once; 520+ transfers total.
- R1=0x05 -> rd_err_o with code 1; no buffer writes; spi_ss_o high before the trailer byte.
- Card always returns 0xFF -> code 2 after exactly 8 polls. Token phase always 0xFF with TOKEN_TIMEOUT=16 -> code 4 after exactly 16 polls.
- Data error token 0x08 after R1=0x00 -> code 3; zero buffer writes.
- rd_start_i with spi_initdone_i=0 -> code 5 next cycle, no xfer_req_o. A start while busy is ignored: exactly one rd_done_o.
- spi_rst_i asserted at data byte 100 -> next cycle: IDLE, spi_ss_o=1, all outputs at reset values. A subsequent start completes normally.
